// File: rtl/turn_signal_ctrl.sv
// Turn-signal controller: synchronizes and debounces three buttons, then runs the OFF/LEFT/RIGHT/HAZ lamp FSM.
// Optional macro TURN_AUTO_CANCEL_EN enables the LEFT/RIGHT dwell timeout and timeout_evt pulse.
module turn_signal_ctrl #(
  parameter int unsigned DEB_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYC = 10
) (
  input  logic       clkout,
  input  logic       rst_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_hazard,
  output logic [1:0] sw,
  output logic       active,
  output logic       timeout_evt
);

  localparam int unsigned NB      = 3;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned B_LEFT  = 0;
  localparam int unsigned B_RIGHT = 1;
  localparam int unsigned B_HAZ   = 2;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_deb_range
    $error("DEB_CYCLES out of range 1..255");
  end
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_tmo_range
    $error("TIMEOUT_CYC out of range 2..65535");
  end

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_LEFT  = 2'b01,
    ST_RIGHT = 2'b10,
    ST_HAZ   = 2'b11
  } state_t;

  logic [NB-1:0]    btn_raw;
  logic [NB-1:0]    sync1_q;
  logic [NB-1:0]    sync2_q;
  logic [NB-1:0]    deb_q;
  logic [NB-1:0]    deb_d_q;
  logic [CNT_W-1:0] cnt_q [NB];
  logic [NB-1:0]    press;

  state_t state_q;
  state_t state_d;

  assign btn_raw = {btn_hazard, btn_right, btn_left};

  // Synchronizer, stability-counter debouncer and edge-detect delay, one lane per button
  always_ff @(posedge clkout or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      deb_d_q <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      deb_d_q <= deb_q;
      for (int i = 0; i < NB; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DEB_LAST) begin
          deb_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign press = deb_q & ~deb_d_q;

`ifdef TURN_AUTO_CANCEL_EN
  localparam int unsigned DWELL_W = 16;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(TIMEOUT_CYC - 1);
  localparam logic [DWELL_W-1:0] DWELL_MAX  = '1;

  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_d;
  logic               tmo_c;
  logic               tmo_q;
  logic               dwell_hit;

  assign dwell_hit = (dwell_q == DWELL_LAST);
`else
  logic dwell_hit;
  assign dwell_hit = 1'b0;
`endif

  // Next-state logic; hazard outranks left/right, and any press outranks the timeout
  always_comb begin
    state_d = state_q;
`ifdef TURN_AUTO_CANCEL_EN
    tmo_c   = 1'b0;
`endif
    case (state_q)
      ST_OFF: begin
        if (press[B_HAZ])                         state_d = ST_HAZ;
        else if (press[B_LEFT] && press[B_RIGHT]) state_d = ST_OFF;
        else if (press[B_LEFT])                   state_d = ST_LEFT;
        else if (press[B_RIGHT])                  state_d = ST_RIGHT;
      end
      ST_LEFT: begin
        if (press[B_HAZ])        state_d = ST_HAZ;
        else if (press[B_LEFT])  state_d = ST_OFF;
        else if (press[B_RIGHT]) state_d = ST_RIGHT;
        else if (dwell_hit) begin
          state_d = ST_OFF;
`ifdef TURN_AUTO_CANCEL_EN
          tmo_c   = 1'b1;
`endif
        end
      end
      ST_RIGHT: begin
        if (press[B_HAZ])        state_d = ST_HAZ;
        else if (press[B_RIGHT]) state_d = ST_OFF;
        else if (press[B_LEFT])  state_d = ST_LEFT;
        else if (dwell_hit) begin
          state_d = ST_OFF;
`ifdef TURN_AUTO_CANCEL_EN
          tmo_c   = 1'b1;
`endif
        end
      end
      ST_HAZ: begin
        if (press[B_HAZ]) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
  end

`ifdef TURN_AUTO_CANCEL_EN
  // Dwell counts only while staying in LEFT/RIGHT; saturates instead of wrapping
  always_comb begin
    dwell_d = '0;
    if (state_d == state_q && (state_q == ST_LEFT || state_q == ST_RIGHT)) begin
      dwell_d = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + DWELL_W'(1);
    end
  end
`endif

  always_ff @(posedge clkout or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
`ifdef TURN_AUTO_CANCEL_EN
      dwell_q <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef TURN_AUTO_CANCEL_EN
      dwell_q <= dwell_d;
      tmo_q   <= tmo_c;
`endif
    end
  end

  // Registered decode so timeout_evt lines up with sw dropping to 00
  always_ff @(posedge clkout or negedge rst_n) begin
    if (!rst_n) begin
      sw     <= 2'b00;
      active <= 1'b0;
`ifdef TURN_AUTO_CANCEL_EN
      timeout_evt <= 1'b0;
`endif
    end else begin
      sw     <= 2'(state_q);
      active <= (state_q != ST_OFF);
`ifdef TURN_AUTO_CANCEL_EN
      timeout_evt <= tmo_q;
`endif
    end
  end

`ifndef TURN_AUTO_CANCEL_EN
  assign timeout_evt = 1'b0;
`endif

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Directed bench for turn_signal_ctrl (DEB_CYCLES=2, TIMEOUT_CYC=8); adapts to TURN_AUTO_CANCEL_EN.
module tb_turn_signal_ctrl;

  logic       clkout = 1'b0;
  logic       rst_n  = 1'b1;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_hazard = 1'b0;
  logic [1:0] sw;
  logic       active;
  logic       timeout_evt;

  int n_checks = 0;
  int n_fail   = 0;

  turn_signal_ctrl #(
    .DEB_CYCLES (2),
    .TIMEOUT_CYC(8)
  ) dut (
    .clkout     (clkout),
    .rst_n      (rst_n),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_hazard (btn_hazard),
    .sw         (sw),
    .active     (active),
    .timeout_evt(timeout_evt)
  );

  always #5 clkout = ~clkout;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clkout);
    #1;
  endtask

  // Leaves the bench 3 time units after a posedge with reset released and buttons low
  task automatic apply_reset();
    btn_left = 1'b0; btn_right = 1'b0; btn_hazard = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (sw !== 2'b00) begin n_fail++; $display("FAIL reset_sw: got %b expected 00", sw); end
    n_checks++;
    if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", active); end
    n_checks++;
    if (timeout_evt !== 1'b0) begin n_fail++; $display("FAIL reset_evt: got %b expected 0", timeout_evt); end
    btn_left = 1'b1;
    tick();
    tick();
    n_checks++;
    if (sw !== 2'b00) begin n_fail++; $display("FAIL reset_hold_sw: got %b expected 00", sw); end
    btn_left = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_left_latency();
    logic [1:0] exp_sw;
    apply_reset();
    for (int e = 0; e <= 7; e++) begin
      btn_left = 1'b1;
      tick();
      exp_sw = (e >= 5) ? 2'b01 : 2'b00;
      n_checks++;
      if (sw !== exp_sw || active !== (exp_sw != 2'b00)) begin
        n_fail++;
        $display("FAIL left_latency edge %0d: got sw=%b active=%b expected sw=%b", e, sw, active, exp_sw);
      end
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    btn_right = 1'b1;
    tick();
    btn_right = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      n_checks++;
      if (sw !== 2'b00) begin
        n_fail++;
        $display("FAIL glitch edge %0d: got sw=%b expected 00", e, sw);
      end
    end
  endtask

  task automatic test_both_in_off();
    apply_reset();
    for (int e = 0; e <= 11; e++) begin
      btn_left = 1'b1; btn_right = 1'b1;
      tick();
      n_checks++;
      if (sw !== 2'b00) begin
        n_fail++;
        $display("FAIL both_in_off edge %0d: got sw=%b expected 00", e, sw);
      end
    end
  endtask

`ifdef TURN_AUTO_CANCEL_EN
  task automatic test_timeout();
    logic [1:0] exp_sw;
    logic       exp_evt;
    apply_reset();
    for (int e = 0; e <= 16; e++) begin
      btn_left = (e <= 5);
      tick();
      exp_sw  = (e >= 5 && e <= 12) ? 2'b01 : 2'b00;
      exp_evt = (e == 13);
      n_checks++;
      if (sw !== exp_sw || timeout_evt !== exp_evt) begin
        n_fail++;
        $display("FAIL timeout edge %0d: got sw=%b evt=%b expected sw=%b evt=%b", e, sw, timeout_evt, exp_sw, exp_evt);
      end
    end
  endtask
`else
  task automatic test_no_cancel();
    logic [1:0] exp_sw;
    apply_reset();
    for (int e = 0; e <= 105; e++) begin
      btn_left = (e <= 5);
      tick();
      exp_sw = (e >= 5) ? 2'b01 : 2'b00;
      n_checks++;
      if (sw !== exp_sw || timeout_evt !== 1'b0) begin
        n_fail++;
        $display("FAIL no_cancel edge %0d: got sw=%b evt=%b expected sw=%b evt=0", e, sw, timeout_evt, exp_sw);
      end
    end
  endtask
`endif

  task automatic test_hazard();
    logic [1:0] exp_sw;
    apply_reset();
    for (int e = 0; e <= 31; e++) begin
      btn_left   = (e <= 5);
      btn_hazard = (e >= 6 && e <= 11) || (e >= 25 && e <= 30);
      btn_right  = (e >= 6 && e <= 11) || (e >= 17 && e <= 22);
      tick();
      if (e < 5)       exp_sw = 2'b00;
      else if (e < 11) exp_sw = 2'b01;
      else if (e < 30) exp_sw = 2'b11;
      else             exp_sw = 2'b00;
      n_checks++;
      if (sw !== exp_sw || active !== (exp_sw != 2'b00) || timeout_evt !== 1'b0) begin
        n_fail++;
        $display("FAIL hazard edge %0d: got sw=%b active=%b evt=%b expected sw=%b", e, sw, active, timeout_evt, exp_sw);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp_sw;
    apply_reset();
    for (int e = 0; e <= 7; e++) begin
      btn_right = 1'b1;
      tick();
      exp_sw = (e >= 5) ? 2'b10 : 2'b00;
      n_checks++;
      if (sw !== exp_sw) begin
        n_fail++;
        $display("FAIL reset_mid_enter edge %0d: got sw=%b expected %b", e, sw, exp_sw);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (sw !== 2'b00 || active !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got sw=%b active=%b expected sw=00 active=0", sw, active);
    end
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      tick();
      exp_sw = (e >= 5) ? 2'b10 : 2'b00;
      n_checks++;
      if (sw !== exp_sw) begin
        n_fail++;
        $display("FAIL reset_mid_release edge %0d: got sw=%b expected %b", e, sw, exp_sw);
      end
    end
    btn_right = 1'b0;
  endtask

  initial begin
    test_reset();
    test_left_latency();
    test_glitch();
    test_both_in_off();
`ifdef TURN_AUTO_CANCEL_EN
    test_timeout();
`else
    test_no_cancel();
`endif
    test_hazard();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/turn_signal_ctrl.md
TURN_SIGNAL_CTRL -- requirements
Module: turn_signal_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 2: consecutive clkout cycles a synchronized button level must hold before it is accepted (range 1..255).
REQ-002 Parameter TIMEOUT_CYC, default 10: clkout cycles a LEFT/RIGHT indication stays active before auto-cancel (range 2..65535).
REQ-003 Port clkout  input  1  divided system clock; all logic on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port btn_left  input  1  raw left-indicator button, active-high, asynchronous to clkout.
REQ-006 Port btn_right  input  1  raw right-indicator button, active-high, asynchronous.
REQ-007 Port btn_hazard  input  1  raw hazard button, active-high, asynchronous.
REQ-008 Port sw  output  2  lamp mode code for the downstream blinker: 00 off, 01 left, 10 right, 11 hazard.
REQ-009 Port active  output  1  high whenever sw is not 00.
REQ-010 Port timeout_evt  output  1  one-cycle pulse on auto-cancel.

Function
REQ-011 Each button SHALL pass a 2-flop synchronizer, then a per-button debouncer with an 8-bit stability counter.
REQ-012 Debouncer: counter clears when the synchronized level equals the debounced level; otherwise it increments, and at count DEB_CYCLES-1 the debounced level flips and the counter clears.
REQ-013 A press SHALL be a rising edge of the debounced level, one cycle wide; releases generate nothing.
REQ-014 Latency: with a raw level held steady, sw SHALL change on the (DEB_CYCLES+3)th clkout rising edge after the first edge sampling the new level.
REQ-015 Glitches shorter than DEB_CYCLES synchronized cycles SHALL produce no press.
REQ-016 FSM states OFF(sw=00), LEFT(01), RIGHT(10), HAZ(11); sw SHALL be a registered decode of state.
REQ-017 Hazard press SHALL take priority over any same-cycle left/right press: OFF/LEFT/RIGHT -> HAZ, HAZ -> OFF.
REQ-018 In HAZ, left/right presses SHALL be ignored.
REQ-019 OFF: left press -> LEFT; right press -> RIGHT; simultaneous left+right press -> stay OFF.
REQ-020 LEFT: left press -> OFF; right press -> RIGHT. RIGHT: right press -> OFF; left press -> LEFT. Simultaneous left+right in LEFT/RIGHT -> OFF.
REQ-021 A 16-bit dwell counter SHALL clear on every state transition and increment every cycle in LEFT/RIGHT, saturating, held at 0 in OFF/HAZ.
REQ-022 A button press in the same cycle as timeout SHALL win; timeout_evt SHALL stay 0 that cycle.
REQ-023 Holding a button continuously SHALL yield exactly one press.

Reset
REQ-024 On rst_n low, immediately and regardless of clock: state OFF, sw=00, active=0, timeout_evt=0, synchronizers, debounced levels and all counters 0.
REQ-025 Reset asserted mid-indication SHALL drop sw to 00 without waiting for an edge; after release a button already held high SHALL register as one new press after the REQ-014 latency.

Configuration
REQ-026 Macro TURN_AUTO_CANCEL_EN defined: when the dwell counter reaches TIMEOUT_CYC-1 in LEFT/RIGHT, next edge -> OFF and timeout_evt=1 for that one cycle.
REQ-027 TURN_AUTO_CANCEL_EN undefined: no dwell counter, LEFT/RIGHT persist until a press changes state, timeout_evt tied 0.

Verification (DEB_CYCLES=2, TIMEOUT_CYC=8, TURN_AUTO_CANCEL_EN defined unless stated)
REQ-028 btn_left held high from edge 0 -> sw=01, active=1 exactly at edge 5; sw stays 00 before.
REQ-029 btn_right high for one cycle only -> sw remains 00 for 20 cycles.
REQ-030 LEFT entered, no further input -> sw=01 for 8 cycles, then sw=00 with timeout_evt=1 for exactly one cycle.
REQ-031 In LEFT, btn_hazard and btn_right pressed on the same edge -> sw=11; second hazard press -> sw=00; right presses during HAZ ignored.
REQ-032 In RIGHT, rst_n pulled low between edges -> sw=00 immediately; release with btn_right held -> sw=10 five edges after release.
REQ-033 TURN_AUTO_CANCEL_EN undefined: LEFT held 100 cycles without input -> sw stays 01, timeout_evt never asserts.
